ecp_out_uart: RTL and testbench
===============================

# ecp_out_uart

Buffered serial transmitter for the ECP8e output port. It sits directly downstream of the core's level output: it captures every byte the core writes on `arch_output_enable`/`arch_output_value` into a small FIFO and shifts the bytes out as 8N1 UART frames. The core cannot stall, so the block never back-pressures it. A write that arrives while the FIFO is full is dropped and recorded in a sticky overflow flag.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  1  byte strobe, driven by `arch_output_enable`; one byte per high cycle.
- `wr_data`  in  8  byte, driven by `arch_output_value`; sampled when `wr_en`=1.
- `ovf_clr`  in  1  clears `overflow`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  `(state != IDLE) || (fifo_count != 0)`.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- `overflow`  out  1  sticky: at least one write was dropped.

## Operation
- **Reset:** while `rst`=1, `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, bit and baud counters=0. FIFO contents are discarded.
- **FIFO:** synchronous, first-word fall-through head. Read/write pointers wrap modulo DEPTH.
- **Write:** accepted when `wr_en`=1 and either `fifo_count`<DEPTH or a pop happens on the same edge.
- **Dropped write:** `wr_en`=1 with `fifo_count`==DEPTH and no pop. The data is discarded and `overflow` is set.
- **Overflow flag:** a set and `ovf_clr` on the same edge leaves `overflow`=1 (set wins). `ovf_clr` alone clears it on the next edge.
- **Count update:** +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if `fifo_count`>0, pop the head into the shift register, clear the baud counter, go to START. `tx` goes to 0 on the same edge.
  - START: drive `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and `tx`=shift[0].
  - DATA: drive each bit for CLKS_PER_BIT cycles, LSB first. Shift right after each bit. After bit 7, go to STOP with `tx`=1.
  - STOP: drive `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT−1. The bit boundary is the edge where it equals CLKS_PER_BIT−1. The counter wraps to 0 on that edge.
- **Write during transmission:** only enqueues. The frame in flight is never altered.

## Timing
- **Latency:** `wr_en` sampled at edge E0 with the FSM in IDLE and the FIFO empty. Then `fifo_count`=1 after E0, the pop happens at E1, and `tx` falls after E1.
- **Frame length:** 10·CLKS_PER_BIT cycles from the `tx` fall to the end of the stop bit.
- **Back-to-back frames:** period 10·CLKS_PER_BIT+1 cycles, with one IDLE cycle of `tx`=1 between the stop bit and the next start bit.
- **`busy` timing:** rises the cycle after the first accepted write. Falls the cycle after STOP→IDLE if the FIFO is empty.
- **Reset mid-frame:** `tx` returns to 1 asynchronously. No partial frame resumes after release.

## Structure
- **Package `ecp_io_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1.
- **Sub-module `ecp_sync_fifo`:** parameterised by width and depth. It carries the push/pop/count/full/empty logic, including the simultaneous push-on-full rule.
- **Top:** instantiates `ecp_sync_fifo` and adds the FSM, baud counter, shift register and overflow flag.

## Test plan
Benches use DEPTH=4 and CLKS_PER_BIT=4.
- **Reset:** assert `rst` asynchronously mid-cycle → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0 immediately, held until release.
- **Single byte:** write 0xA5 at E0 → `tx` low for cycles after E1..E5. Then 1,0,1,0,0,1,0,1, each 4 cycles, stop high 4 cycles. `busy`=0 one cycle after STOP.
- **Burst with overflow:** `wr_en`=1 for 6 consecutive edges, data 0x01..0x06 → `fifo_count` reads 1,1,2,3,4,4. 0x06 is dropped and `overflow`=1. Line carries 0x01..0x05 in order, each frame 41 cycles apart.
- **Push on full:** FIFO full with the FSM in IDLE, write 0x7E on the pop edge → accepted, `fifo_count` stays 4, `overflow` stays 0.
- **Overflow flag priority:** `ovf_clr`=1 on the same edge as a dropped write → `overflow` stays 1. `ovf_clr` alone next cycle → 0.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 2 bytes queued → `tx`=1. After release, `fifo_count`=0 and no frame starts.

Source files
------------

// File: rtl/ecp_io_pkg.sv
// Shared types and constants for the ECP8e output-port UART.
package ecp_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ecp_sync_fifo.sv
// Synchronous FIFO with a fall-through head; a push on a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module ecp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ecp_out_uart.sv
// Buffered 8N1 UART transmitter fed by the core's non-stallable output strobe.
module ecp_out_uart
    import ecp_io_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   ovf_clr,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(UART_DATA_BITS);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [BW-1:0]             baud_cnt;
    logic [BW-1:0]             baud_nxt;
    logic [IW-1:0]             bit_idx;
    logic [IW-1:0]             bit_nxt;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_nxt;
    logic                      tx_nxt;
    logic                      pop_c;
    logic                      drop_c;
    logic                      baud_done_c;
    logic                      last_bit_c;
    logic [7:0]                fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;

    ecp_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop_c),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done_c = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign last_bit_c  = (bit_idx == IW'(UART_DATA_BITS - 1));
    assign drop_c      = wr_en && fifo_full && !pop_c;
    assign busy        = (state != IDLE) || (fifo_count != '0);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: advance on bit boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty)                state_nxt = START;
            START:   if (baud_done_c)                state_nxt = DATA;
            DATA:    if (baud_done_c && last_bit_c)  state_nxt = STOP;
            STOP:    if (baud_done_c)                state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: pop, line level, counters, shifter.
    always_comb begin
        pop_c     = 1'b0;
        tx_nxt    = tx;
        baud_nxt  = baud_done_c ? '0 : baud_cnt + BW'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        case (state)
            IDLE: begin
                tx_nxt   = UART_IDLE_LEVEL;
                baud_nxt = '0;
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shift_nxt = fifo_dout;
                    bit_nxt   = '0;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_done_c) begin
                    tx_nxt  = shift[0];
                    bit_nxt = '0;
                end
            end
            DATA: begin
                if (baud_done_c) begin
                    if (last_bit_c) begin
                        tx_nxt = UART_IDLE_LEVEL;
                    end else begin
                        shift_nxt = shift >> 1;
                        tx_nxt    = shift[1];
                        bit_nxt   = bit_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                tx_nxt = UART_IDLE_LEVEL;
            end
            default: begin
                tx_nxt   = UART_IDLE_LEVEL;
                baud_nxt = '0;
            end
        endcase
    end

    // Datapath registers and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= UART_IDLE_LEVEL;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
        end else begin
            tx       <= tx_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            if (drop_c)       overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecp_out_uart.sv
// Directed bench for ecp_out_uart with DEPTH=4, CLKS_PER_BIT=4.
module tb_ecp_out_uart;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ecp_out_uart #(
        .DEPTH        (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor: decodes frames (4 clocks per bit), records byte, fall cycle, stop level.
    int         cyc = 0;
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_fall = 0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act  = 1'b1;
                mon_cnt  = 0;
                mon_fall = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
                mon_sh = {tx, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                rx_q.push_back(mon_sh);
                rx_t.push_back(mon_fall);
                rx_stop.push_back(tx);
                mon_act = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the pop edge; walks the whole frame cycle by cycle.
    task automatic frame_check(input logic [7:0] b);
        check("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("start_bit", 32'(tx), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check("data_bit", 32'(tx), 32'(b[k]));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stop_bit", 32'(tx), 32'd1);
            check("busy_in_stop", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int         burst_cnt [6];
        int         pof_cnt   [5];
        logic [7:0] pof_bytes [6];
        burst_cnt = '{1, 1, 2, 3, 4, 4};
        pof_cnt   = '{1, 1, 2, 3, 4};
        pof_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h7E};

        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        tick(); tick();
        check("rst_hold_tx", 32'(tx), 32'd1);
        check("rst_hold_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single byte 0xA5.
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        check("single_count_e0", 32'(fifo_count), 32'd1);
        check("single_busy_e0", 32'(busy), 32'd1);
        check("single_tx_e0", 32'(tx), 32'd1);
        wr_en = 1'b0;
        tick();
        check("single_count_e1", 32'(fifo_count), 32'd0);
        frame_check(8'hA5);
        tick();
        check("single_busy_end", 32'(busy), 32'd0);
        check("single_tx_end", 32'(tx), 32'd1);

        // Burst of six writes into a four-deep FIFO; 0x06 is dropped.
        tick();
        rx_q.delete(); rx_t.delete(); rx_stop.delete();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
            check("burst_count", 32'(fifo_count), 32'(burst_cnt[i]));
        end
        wr_en = 1'b0;
        check("burst_ovf", 32'(overflow), 32'd1);
        wait_frames(5, 5 * 41 + 60);
        wait_idle(20);
        tick(); tick();
        check("burst_nframes", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check("burst_byte", 32'(rx_q[i]), 32'(i + 1));
            check("burst_stop", 32'(rx_stop[i]), 32'd1);
            if (i > 0) check("burst_period", 32'(rx_t[i] - rx_t[i-1]), 32'd41);
        end
        check("burst_ovf_sticky", 32'(overflow), 32'd1);
        check("burst_count_end", 32'(fifo_count), 32'd0);

        // Clear alone.
        ovf_clr = 1'b1;
        tick();
        check("ovf_clr_alone", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;

        // Fill FIFO during a frame, then push on the IDLE pop edge.
        rx_q.delete(); rx_t.delete(); rx_stop.delete();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = pof_bytes[i];
            tick();
            check("pof_fill_count", 32'(fifo_count), 32'(pof_cnt[i]));
        end
        wr_en = 1'b0;
        repeat (37) tick();
        check("pof_idle_count", 32'(fifo_count), 32'd4);
        check("pof_idle_tx", 32'(tx), 32'd1);
        check("pof_idle_busy", 32'(busy), 32'd1);
        wr_en = 1'b1; wr_data = 8'h7E;
        tick();
        check("pof_count", 32'(fifo_count), 32'd4);
        check("pof_ovf", 32'(overflow), 32'd0);
        check("pof_tx_start", 32'(tx), 32'd0);

        // Dropped write with simultaneous clear: set wins.
        wr_data = 8'h99; ovf_clr = 1'b1;
        tick();
        check("prio_ovf_set", 32'(overflow), 32'd1);
        check("prio_count", 32'(fifo_count), 32'd4);
        wr_en = 1'b0;
        tick();
        check("prio_ovf_clr", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;
        wait_frames(6, 6 * 41 + 60);
        wait_idle(20);
        tick(); tick();
        check("pof_nframes", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check("pof_byte", 32'(rx_q[i]), 32'(pof_bytes[i]));
        if (rx_t.size() >= 2)
            check("pof_period", 32'(rx_t[1] - rx_t[0]), 32'd41);

        // Reset during DATA bit 3 with two bytes queued.
        rx_q.delete(); rx_t.delete(); rx_stop.delete();
        wr_en = 1'b1; wr_data = 8'hC3; tick();
        wr_data = 8'hD1; tick();
        wr_data = 8'hD2; tick();
        wr_en = 1'b0;
        check("mid_count", 32'(fifo_count), 32'd2);
        repeat (16) tick();
        check("mid_bit3", 32'(tx), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        tick(); tick();
        check("mid_rst_hold_tx", 32'(tx), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("post_mid_tx", 32'(tx), 32'd1);
        end
        check("post_mid_count", 32'(fifo_count), 32'd0);
        check("post_mid_busy", 32'(busy), 32'd0);
        check("post_mid_frames", 32'(rx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
